// File: rtl/me_pkg.sv
// Shared constants and types for the fractional motion-estimation path.
// Candidate index = v*5 + h over the 5x5 grid of fractional positions.
package me_pkg;

  localparam int PIX_W  = 8;
  localparam int ROW_W  = 12;
  localparam int N_CAND = 25;
  localparam int MAX_H  = 8;

  typedef enum logic [2:0] {
    V_UH = 3'd0, V_UQ = 3'd1, V_M = 3'd2, V_LQ = 3'd3, V_LH = 3'd4
  } vpos_e;

  typedef enum logic [2:0] {
    H_H = 3'd0, H_Q = 3'd1, H_F = 3'd2, H_R = 3'd3, H_I = 3'd4
  } hpos_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_SEARCH = 2'd2, ST_DONE = 2'd3
  } state_e;

  function automatic logic [4:0] cand_idx(input vpos_e v, input hpos_e h);
    return ({2'b00, v} * 5'd5) + {2'b00, h};
  endfunction

endpackage

// File: rtl/sad_acc_bank.sv
// Bank of N_CAND per-candidate SAD accumulators; a load overwrites, an add
// accumulates the zero-extended row SAD.
module sad_acc_bank #(
  parameter int ROW_W  = me_pkg::ROW_W,
  parameter int N_CAND = me_pkg::N_CAND,
  parameter int ACC_W  = ROW_W + $clog2(me_pkg::MAX_H)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      add,
  input  logic                      clear,
  input  logic [N_CAND*ROW_W-1:0]   row_sad,
  output logic [N_CAND*ACC_W-1:0]   sad_all
);

  for (genvar i = 0; i < N_CAND; i++) begin : g_acc
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] row_ext_s;

    assign row_ext_s = {{(ACC_W-ROW_W){1'b0}}, row_sad[i*ROW_W +: ROW_W]};

    // Per-candidate accumulator register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_r <= '0;
      end else if (clear) begin
        acc_r <= '0;
      end else if (load) begin
        acc_r <= row_ext_s;
      end else if (add) begin
        acc_r <= acc_r + row_ext_s;
      end else begin
        acc_r <= acc_r;
      end
    end

    assign sad_all[i*ACC_W +: ACC_W] = acc_r;
  end

endmodule

// File: rtl/frac_sad_search.sv
// Accumulates candidate row SADs over a block, then scans one candidate per
// cycle for the minimum (ties keep the lowest index) and hands it off.
module frac_sad_search #(
  parameter int  ROW_W  = me_pkg::ROW_W,
  parameter int  N_CAND = me_pkg::N_CAND,
  parameter int  MAX_H  = me_pkg::MAX_H,
  localparam int ACC_W  = ROW_W + $clog2(MAX_H),
  localparam int IDX_W  = $clog2(N_CAND),
  localparam int CFG_W  = $clog2(MAX_H) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CAND*ROW_W-1:0]  row_sad,
  input  logic [CFG_W-1:0]         cfg_rows,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         best_idx,
  output logic [ACC_W-1:0]         best_sad,
  output logic [N_CAND*ACC_W-1:0]  sad_all
);
  import me_pkg::*;

  state_e                  state_r, state_nxt_s;
  logic [CFG_W-1:0]        rows_eff_s, rows_eff_r, row_cnt_r;
  logic [IDX_W-1:0]        scan_idx_r, scan_best_idx_r;
  logic [ACC_W-1:0]        scan_best_r, cur_sad_s;
  logic                    in_ready_s, hs_s, load_s, add_s, clear_s;
  logic                    scan_last_s, take_s;
  logic [N_CAND*ACC_W-1:0] acc_all_s;

  sad_acc_bank #(.ROW_W(ROW_W), .N_CAND(N_CAND), .ACC_W(ACC_W)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .add     (add_s),
    .clear   (clear_s),
    .row_sad (row_sad),
    .sad_all (acc_all_s)
  );

  assign cur_sad_s   = acc_all_s[scan_idx_r*ACC_W +: ACC_W];
  assign scan_last_s = (scan_idx_r == IDX_W'(N_CAND-1));
  assign take_s      = (scan_idx_r == '0) || (cur_sad_s < scan_best_r);
  assign in_ready    = in_ready_s;

  // Block height clamp: 0 means one row, anything above MAX_H means MAX_H.
  always_comb begin
    rows_eff_s = cfg_rows;
    if (cfg_rows == '0) begin
      rows_eff_s = CFG_W'(1);
    end else if (cfg_rows > CFG_W'(MAX_H)) begin
      rows_eff_s = CFG_W'(MAX_H);
    end else begin
      rows_eff_s = cfg_rows;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort wins everywhere except DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (abort) state_nxt_s = ST_IDLE;
        else if (in_valid) state_nxt_s = (rows_eff_s == CFG_W'(1)) ? ST_SEARCH : ST_ACCUM;
        else state_nxt_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (abort) state_nxt_s = ST_IDLE;
        else if (in_valid && (row_cnt_r + CFG_W'(1) == rows_eff_r)) state_nxt_s = ST_SEARCH;
        else state_nxt_s = ST_ACCUM;
      end
      ST_SEARCH: begin
        if (abort) state_nxt_s = ST_IDLE;
        else if (scan_last_s) state_nxt_s = ST_DONE;
        else state_nxt_s = ST_SEARCH;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake and accumulator-bank controls.
  always_comb begin
    in_ready_s = ((state_r == ST_IDLE) || (state_r == ST_ACCUM)) && !abort;
    hs_s       = in_valid && in_ready_s;
    load_s     = hs_s && (state_r == ST_IDLE);
    add_s      = hs_s && (state_r == ST_ACCUM);
    clear_s    = abort && (state_r != ST_DONE);
  end

  // Row counter and latched block height.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_cnt_r  <= '0;
      rows_eff_r <= '0;
    end else if (clear_s) begin
      row_cnt_r  <= '0;
      rows_eff_r <= rows_eff_r;
    end else if (load_s) begin
      row_cnt_r  <= CFG_W'(1);
      rows_eff_r <= rows_eff_s;
    end else if (add_s) begin
      row_cnt_r  <= row_cnt_r + CFG_W'(1);
      rows_eff_r <= rows_eff_r;
    end else begin
      row_cnt_r  <= row_cnt_r;
      rows_eff_r <= rows_eff_r;
    end
  end

  // Sequential min scan; visible outputs only change on the final compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx_r      <= '0;
      scan_best_r     <= '0;
      scan_best_idx_r <= '0;
      best_idx        <= '0;
      best_sad        <= '0;
      sad_all         <= '0;
    end else if ((state_r == ST_SEARCH) && !abort) begin
      scan_idx_r <= scan_last_s ? '0 : scan_idx_r + IDX_W'(1);
      if (take_s) begin
        scan_best_r     <= cur_sad_s;
        scan_best_idx_r <= scan_idx_r;
      end else begin
        scan_best_r     <= scan_best_r;
        scan_best_idx_r <= scan_best_idx_r;
      end
      if (scan_last_s) begin
        best_idx <= take_s ? scan_idx_r : scan_best_idx_r;
        best_sad <= take_s ? cur_sad_s  : scan_best_r;
        sad_all  <= acc_all_s;
      end else begin
        best_idx <= best_idx;
        best_sad <= best_sad;
        sad_all  <= sad_all;
      end
    end else begin
      scan_idx_r <= '0;
    end
  end

  // Registered result-valid flag, high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_frac_sad_search.sv
// Scoreboard bench for frac_sad_search: expected results are queued as blocks
// are driven and compared when the DUT raises out_valid.
module tb_frac_sad_search;

  localparam int RW = 12;
  localparam int NC = 25;
  localparam int AW = 15;

  typedef logic [NC*RW-1:0] row_t;
  typedef struct {
    int               idx;
    int               sad;
    logic [NC*AW-1:0] all;
  } exp_t;

  logic             clk, rst_n, in_valid, in_ready, abort, out_valid, out_ready;
  row_t             row_sad;
  logic [3:0]       cfg_rows;
  logic [4:0]       best_idx;
  logic [AW-1:0]    best_sad;
  logic [NC*AW-1:0] sad_all;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  exp_t sb[$];
  exp_t last_exp;

  frac_sad_search dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .row_sad(row_sad), .cfg_rows(cfg_rows), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .best_idx(best_idx),
    .best_sad(best_sad), .sad_all(sad_all)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic row_t pack_row(input int v[NC]);
    row_t r;
    for (int i = 0; i < NC; i++) r[i*RW +: RW] = v[i][RW-1:0];
    return r;
  endfunction

  function automatic int eff_rows(input int cfg);
    if (cfg == 0) return 1;
    if (cfg > 8) return 8;
    return cfg;
  endfunction

  // Model of a block made of eff identical rows.
  function automatic exp_t model(input int v[NC], input int eff);
    exp_t e;
    e.idx = 0;
    e.sad = v[0] * eff;
    for (int i = 0; i < NC; i++) begin
      e.all[i*AW +: AW] = AW'(v[i] * eff);
      if (v[i] * eff < e.sad) begin
        e.sad = v[i] * eff;
        e.idx = i;
      end
    end
    return e;
  endfunction

  task automatic send_row(input row_t r, input int cfg);
    bit ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    row_sad  = r;
    cfg_rows = cfg[3:0];
    for (int k = 0; k < 100; k++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check_eq("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    last_acc_cyc = cyc;
  endtask

  task automatic send_block(input int v[NC], input int cfg, input int n);
    if (n == eff_rows(cfg)) sb.push_back(model(v, eff_rows(cfg)));
    for (int r = 0; r < n; r++) send_row(pack_row(v), cfg);
  endtask

  task automatic wait_result(input bit drain);
    bit   seen = 1'b0;
    exp_t e;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("out_valid_seen", seen, 1);
    if (!seen) return;
    check_eq("latency", cyc - last_acc_cyc, 25);
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    last_exp = e;
    check_eq("best_idx", best_idx, e.idx);
    check_eq("best_sad", best_sad, e.sad);
    check_eq("sad_all", sad_all, e.all);
    check_eq("in_ready_done", in_ready, 0);
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq("out_valid_drop", out_valid, 0);
      check_eq("best_sad_hold", best_sad, e.sad);
    end
  endtask

  initial begin
    int v[NC];
    int w[NC];

    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    row_sad = '0; cfg_rows = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_best_idx", best_idx, 0);
    check_eq("rst_best_sad", best_sad, 0);
    check_eq("rst_sad_all", sad_all, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Height 8, minimum of zero at candidate 12.
    for (int i = 0; i < NC; i++) v[i] = (i == 12) ? 0 : i + 1;
    send_block(v, 8, 8);
    wait_result(1'b1);
    check_eq("acc24", sad_all[24*AW +: AW], 200);

    // Ties resolve to lowest index; cfg 0 means a single row.
    for (int i = 0; i < NC; i++) v[i] = 100;
    send_block(v, 4, 4);
    wait_result(1'b1);
    send_block(v, 0, 1);
    wait_result(1'b1);

    // Full-scale rows must not wrap; 15 clamps to 8.
    for (int i = 0; i < NC; i++) v[i] = 4095;
    send_block(v, 8, 8);
    wait_result(1'b1);
    send_block(v, 15, 8);
    wait_result(1'b1);

    // Abort after three rows, with a row offered alongside it.
    for (int i = 0; i < NC; i++) v[i] = 3000;
    send_block(v, 8, 3);
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1;
    #1;
    check_eq("abort_in_ready", in_ready, 0);
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("abort_idle_ready", in_ready, 1);
    repeat (30) @(negedge clk);
    check_eq("abort_no_valid", out_valid, 0);
    for (int i = 0; i < NC; i++) v[i] = (i == 7) ? 5 : 9;
    send_block(v, 1, 1);
    wait_result(1'b1);

    // Back-pressure: result held while a new row waits.
    for (int i = 0; i < NC; i++) v[i] = (i == 20) ? 2 : 40;
    for (int i = 0; i < NC; i++) w[i] = (i == 3) ? 1 : 50;
    send_block(v, 1, 1);
    wait_result(1'b0);
    in_valid = 1'b1; row_sad = pack_row(w); cfg_rows = 4'd1;
    sb.push_back(model(w, 1));
    for (int k = 0; k < 10; k++) begin
      #1;
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_best_idx", best_idx, last_exp.idx);
      check_eq("hold_best_sad", best_sad, last_exp.sad);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_out_valid_drop", out_valid, 0);
    check_eq("bp_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    last_acc_cyc = cyc;
    wait_result(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
